bf_sweep_driver: RTL and testbench

Sequential stimulus generator and checker that sits on the driving side of the 3-input boolean-function blocks. It walks the three inputs a, b, c through all 8 combinations, waits a programmable settle time per vector, samples the function output x, and compares it with an expected truth table. It reports per-vector mismatches, an error count and a pass flag through a start/done handshake, so lab boards and benches can self-check any 3-input function.

---
 rtl/bf_pkg.sv | 17 +
 rtl/bf_sweep_driver.sv | 137 +++++++++++++
 tb/tb_bf_sweep_driver.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/bf_pkg.sv
// Shared definitions for the 3-input boolean-function blocks and their drivers.
package bf_pkg;

  // Number of input combinations of a 3-input function.
  localparam int VEC_N = 8;

  // Truth table of bf2a, x = (~a & ~b) | ~c, indexed by {a,b,c}.
  localparam logic [VEC_N-1:0] BF2A_TT = 8'h57;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    SAMPLE = 2'd2,
    FINISH = 2'd3
  } bf_state_e;

endpackage

// File: rtl/bf_sweep_driver.sv
// Sweeps a,b,c through all 8 vectors, holds each for SETTLE cycles before
// sampling x_in, and checks it against the EXPECT truth table.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | results held; waiting for start
// WAIT   | drive current vector, count down the settle time
// SAMPLE | compare x_in with EXPECT[idx]; advance or finish
// FINISH | publish pass, pulse done, drop busy
module bf_sweep_driver
  import bf_pkg::*;
#(
  parameter logic [VEC_N-1:0] EXPECT = BF2A_TT,
  parameter int unsigned      SETTLE = 1        // legal range 1..15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       x_in,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_cnt,
  output logic [7:0] fail_vec
);

  localparam logic [3:0] SETTLE_LD = 4'(SETTLE);
  localparam logic [2:0] IDX_LAST  = 3'(VEC_N - 1);

  bf_state_e  state_q, state_n;
  logic [2:0] idx_q, idx_n;
  logic [3:0] cnt_q, cnt_n;
  logic [2:0] abc_q, abc_n;
  logic       busy_q, busy_n;
  logic       done_q, done_n;
  logic       pass_q, pass_n;
  logic [3:0] err_q, err_n;
  logic [7:0] fv_q, fv_n;

  // State, sweep position, settle counter and all result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      abc_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      fv_q    <= '0;
    end else begin
      state_q <= state_n;
      idx_q   <= idx_n;
      cnt_q   <= cnt_n;
      abc_q   <= abc_n;
      busy_q  <= busy_n;
      done_q  <= done_n;
      pass_q  <= pass_n;
      err_q   <= err_n;
      fv_q    <= fv_n;
    end
  end

  // Next-state and next-register values; everything holds unless changed.
  always_comb begin
    state_n = state_q;
    idx_n   = idx_q;
    cnt_n   = cnt_q;
    abc_n   = abc_q;
    busy_n  = busy_q;
    done_n  = 1'b0;
    pass_n  = pass_q;
    err_n   = err_q;
    fv_n    = fv_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          idx_n   = '0;
          cnt_n   = SETTLE_LD;
          err_n   = '0;
          fv_n    = '0;
          pass_n  = 1'b0;
          busy_n  = 1'b1;
          state_n = WAIT;
        end
      end

      WAIT: begin
        abc_n = idx_q;
        cnt_n = cnt_q - 4'd1;
        // <= rather than == so a zero load cannot underflow into a long stall
        if (cnt_q <= 4'd1) begin
          state_n = SAMPLE;
        end
      end

      SAMPLE: begin
        if (x_in != EXPECT[idx_q]) begin
          fv_n[idx_q] = 1'b1;
          err_n       = err_q + 4'd1;
        end
        // Last vector is detected explicitly so idx never wraps.
        if (idx_q == IDX_LAST) begin
          state_n = FINISH;
        end else begin
          idx_n   = idx_q + 3'd1;
          cnt_n   = SETTLE_LD;
          state_n = WAIT;
        end
      end

      FINISH: begin
        done_n  = 1'b1;
        pass_n  = (err_q == 4'd0);
        busy_n  = 1'b0;
        state_n = IDLE;
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign {a, b, c} = abc_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_cnt   = err_q;
  assign fail_vec  = fv_q;

endmodule

// File: tb/tb_bf_sweep_driver.sv
// Scoreboard bench: two drivers (SETTLE=1 and SETTLE=3) each checking a
// modelled bf2a function; expected results are queued at start and popped on done.
module tb_bf_sweep_driver;
  import bf_pkg::*;

  typedef struct {
    int         due;
    logic [3:0] err;
    logic [7:0] fv;
    logic       pass;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic start1, start3;
  logic x1, x3;
  logic a1, b1, c1, busy1, done1, pass1;
  logic a3, b3, c3, busy3, done3, pass3;
  logic [3:0] err1, err3;
  logic [7:0] fv1, fv3;

  int mode1, mode3;
  int cyc = 0;
  int n_chk = 0;
  int n_err = 0;
  exp_t q1[$];
  exp_t q3[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bf_sweep_driver #(.EXPECT(BF2A_TT), .SETTLE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .x_in(x1),
    .a(a1), .b(b1), .c(c1), .busy(busy1), .done(done1), .pass(pass1),
    .err_cnt(err1), .fail_vec(fv1)
  );

  bf_sweep_driver #(.EXPECT(BF2A_TT), .SETTLE(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .x_in(x3),
    .a(a3), .b(b3), .c(c3), .busy(busy3), .done(done3), .pass(pass3),
    .err_cnt(err3), .fail_vec(fv3)
  );

  // mode 0: correct bf2a, 1: constant 1, 2: inverted bf2a
  function automatic logic model_x(input int mode, input logic [2:0] v);
    logic [7:0] tt;
    tt = 8'h57;
    case (mode)
      1:       return 1'b1;
      2:       return ~tt[v];
      default: return tt[v];
    endcase
  endfunction

  assign x1 = model_x(mode1, {a1, b1, c1});
  assign x3 = model_x(mode3, {a3, b3, c3});

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp_v, cyc);
    end
  endtask

  // Expected result of a sweep started (start driven) at negedge cycle drv.
  function automatic exp_t make_exp(input int mode, input int settle, input int drv);
    exp_t e;
    logic [7:0] tt;
    tt    = 8'h57;
    e.fv  = '0;
    e.err = '0;
    for (int v = 0; v < 8; v++) begin
      if (model_x(mode, 3'(v)) != tt[v]) begin
        e.fv[v] = 1'b1;
        e.err   = e.err + 4'd1;
      end
    end
    e.pass = (e.err == 4'd0);
    e.due  = drv + 1 + 8 * (settle + 1) + 1;
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (done1) begin
      if (q1.size() == 0) chk("d1_unexpected_done", q1.size(), 1);
      else begin
        e = q1.pop_front();
        chk("d1_done_cycle", cyc, e.due);
        chk("d1_err_cnt", err1, e.err);
        chk("d1_fail_vec", fv1, e.fv);
        chk("d1_pass", pass1, e.pass);
        chk("d1_busy_at_done", busy1, 0);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (done3) begin
      if (q3.size() == 0) chk("d3_unexpected_done", q3.size(), 1);
      else begin
        e = q3.pop_front();
        chk("d3_done_cycle", cyc, e.due);
        chk("d3_err_cnt", err3, e.err);
        chk("d3_fail_vec", fv3, e.fv);
        chk("d3_pass", pass3, e.pass);
        chk("d3_busy_at_done", busy3, 0);
      end
    end
  end

  task automatic drain(input string tag);
    for (int i = 0; i < 200; i++) begin
      if (q1.size() == 0 && q3.size() == 0) break;
      @(negedge clk);
    end
    chk(tag, q1.size() + q3.size(), 0);
  endtask

  task automatic sweep1(input int mode, input string tag);
    mode1 = mode;
    @(negedge clk);
    q1.push_back(make_exp(mode, 1, cyc));
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    drain(tag);
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  initial begin
    int k;
    rst_n  = 1'b0;
    start1 = 1'b0;
    start3 = 1'b0;
    mode1  = 0;
    mode3  = 0;
    repeat (3) @(negedge clk);
    chk("rst_dut1", {a1, b1, c1, busy1, done1, pass1, err1, fv1}, 0);
    chk("rst_dut3", {a3, b3, c3, busy3, done3, pass3, err3, fv3}, 0);
    rst_n = 1'b1;

    // Correct model, SETTLE=1: also walk the vector sequence on a,b,c.
    @(negedge clk);
    k = cyc;
    q1.push_back(make_exp(0, 1, k));
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    chk("t1_busy_after_accept", busy1, 1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("t1_vector", {a1, b1, c1}, i);
      @(negedge clk);
    end
    drain("t1_timeout");
    repeat (3) @(negedge clk);
    chk("t1_pass_held", pass1, 1);
    chk("t1_abc_held", {a1, b1, c1}, 7);

    sweep1(1, "t2_timeout");
    sweep1(2, "t3_timeout");

    // SETTLE=3 with a start pulse mid-sweep that must be ignored.
    @(negedge clk);
    k = cyc;
    q3.push_back(make_exp(0, 3, k));
    start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    wait_until(k + 10);
    start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    drain("t4_timeout");

    // Reset mid-sweep: immediate clear, no done; next sweep normal.
    mode1 = 1;
    @(negedge clk);
    k = cyc;
    q1.push_back(make_exp(1, 1, k));
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    wait_until(k + 9);
    chk("t5_busy_before_rst", busy1, 1);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_dut1", {a1, b1, c1, busy1, done1, pass1, err1, fv1}, 0);
    chk("t5_rst_dut3", {a3, b3, c3, busy3, done3, pass3, err3, fv3}, 0);
    q1.delete();
    repeat (12) @(negedge clk);
    rst_n = 1'b1;
    sweep1(0, "t5_timeout");

    // Start held high: back-to-back sweeps every 18 cycles.
    mode1 = 1;
    @(negedge clk);
    k = cyc;
    for (int s = 0; s < 3; s++) q1.push_back(make_exp(1, 1, k + 18 * s));
    start1 = 1'b1;
    for (int s = 0; s < 3; s++) begin
      wait_until(k + 1 + 18 * s);
      chk("t6_err_clear_on_accept", err1, 0);
    end
    start1 = 1'b0;
    drain("t6_timeout");
    repeat (3) @(negedge clk);
    chk("t6_idle_after", busy1, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
